op_issuer: RTL and testbench

- Initiator side of the opr/start/done operation handshake; the operation controller is the responder.
- Steps through a small program ROM of opcodes. For each opcode it issues `opr` with a one-cycle `start` pulse, then waits for the responder's `done` before moving on.
- Provides halt, invalid-opcode and watchdog-timeout handling so the top level can run multi-operation sequences unattended.

---
 rtl/op_issuer.sv | 147 ++++++++++++++
 tb/tb_op_issuer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/op_issuer.sv
// Initiator side of the opr/start/done handshake: walks a program ROM, issues each
// opcode with a one-cycle start pulse and waits for done, with halt/invalid/timeout handling.
module op_issuer #(
    parameter int OPR_W   = 4,
    parameter int PC_W    = 5,
    parameter int TIMEOUT = 63
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    output logic [PC_W-1:0]  pc,
    input  logic [OPR_W-1:0] instr_data,
    output logic [OPR_W-1:0] opr,
    output logic             start,
    input  logic             done,
    output logic             busy,
    output logic             halted,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [PC_W:0]    issued_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_HALT, S_ERROR
    } state_t;

    localparam logic [OPR_W-1:0] OP_HALT  = OPR_W'(15);
    localparam logic [7:0]       WD_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [1:0]       ERR_NONE    = 2'b00;
    localparam logic [1:0]       ERR_INVALID = 2'b01;
    localparam logic [1:0]       ERR_TIMEOUT = 2'b10;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [OPR_W-1:0]   opr_q, opr_d;
    logic [PC_W:0]      cnt_q, cnt_d;
    logic [7:0]         wd_q, wd_d;
    logic [1:0]         err_code_q, err_code_d;
    logic               start_q, start_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic               error_q, error_d;

    function automatic logic is_valid(input logic [OPR_W-1:0] op);
        case (op)
            OPR_W'(0), OPR_W'(1), OPR_W'(2), OPR_W'(3), OPR_W'(4),
            OPR_W'(6), OPR_W'(8), OPR_W'(9), OPR_W'(10): is_valid = 1'b1;
            default:                                     is_valid = 1'b0;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        pc_d       = pc_q;
        opr_d      = opr_q;
        cnt_d      = cnt_q;
        wd_d       = wd_q;
        err_code_d = err_code_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (run) begin
                    pc_d    = '0;
                    cnt_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (instr_data == OP_HALT) begin
                    state_d = S_HALT;
                end else if (!is_valid(instr_data)) begin
                    err_code_d = ERR_INVALID;
                    state_d    = S_ERROR;
                end else begin
                    opr_d   = instr_data;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes precedence over a watchdog expiring on the same edge
                if (done) begin
                    cnt_d = cnt_q + (PC_W+1)'(1);
                    if (pc_q == '1) begin
                        state_d = S_HALT;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_FETCH;
                    end
                end else if (wd_q == WD_LIMIT) begin
                    err_code_d = ERR_TIMEOUT;
                    state_d    = S_ERROR;
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        // Status outputs are registered copies of the state being entered.
        start_d  = (state_d == S_ISSUE);
        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) || (state_d == S_WAIT);
        halted_d = (state_d == S_HALT);
        error_d  = (state_d == S_ERROR);
    end

    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            opr_q      <= '0;
            cnt_q      <= '0;
            wd_q       <= '0;
            err_code_q <= ERR_NONE;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            opr_q      <= opr_d;
            cnt_q      <= cnt_d;
            wd_q       <= wd_d;
            err_code_q <= err_code_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            error_q    <= error_d;
        end
    end

    assign pc           = pc_q;
    assign opr          = opr_q;
    assign start        = start_q;
    assign busy         = busy_q;
    assign halted       = halted_q;
    assign error        = error_q;
    assign err_code     = err_code_q;
    assign issued_count = cnt_q;

endmodule

// File: tb/tb_op_issuer.sv
// Directed bench for op_issuer: one default instance (PC_W=5) plus a PC_W=2 instance
// for the no-wrap program end.
module tb_op_issuer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        run = 1'b0, done = 1'b0;
    logic [4:0]  pc;
    logic [3:0]  instr_data, opr;
    logic        start, busy, halted, error;
    logic [1:0]  err_code;
    logic [5:0]  issued_count;

    logic        run2 = 1'b0, done2 = 1'b0;
    logic [1:0]  pc2;
    logic [3:0]  instr_data2, opr2;
    logic        start2, busy2, halted2, error2;
    logic [1:0]  err_code2;
    logic [2:0]  issued_count2;

    logic [3:0]  rom  [32];
    logic [3:0]  rom2 [4];

    int total = 0;
    int bad   = 0;

    int       pulses = 0, hi_cycles = 0;
    logic     start_prev = 1'b0;
    logic [3:0] opr_log [16];

    assign instr_data  = rom[pc];
    assign instr_data2 = rom2[pc2];

    op_issuer #(.OPR_W(4), .PC_W(5), .TIMEOUT(63)) dut (
        .clock(clock), .reset(reset), .run(run), .pc(pc), .instr_data(instr_data),
        .opr(opr), .start(start), .done(done), .busy(busy), .halted(halted),
        .error(error), .err_code(err_code), .issued_count(issued_count)
    );

    op_issuer #(.OPR_W(4), .PC_W(2), .TIMEOUT(63)) dut2 (
        .clock(clock), .reset(reset), .run(run2), .pc(pc2), .instr_data(instr_data2),
        .opr(opr2), .start(start2), .done(done2), .busy(busy2), .halted(halted2),
        .error(error2), .err_code(err_code2), .issued_count(issued_count2)
    );

    always #5 clock = ~clock;

    // Start-pulse monitor for the default instance, sampled mid-cycle.
    always @(negedge clock) begin
        if (start) begin
            hi_cycles++;
            if (!start_prev) begin
                opr_log[pulses % 16] = opr;
                pulses++;
            end
        end
        start_prev = start;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic start_run();
        run = 1'b1;
        tick();
        run = 1'b0;
        tick();
    endtask

    // Called with the DUT in ISSUE; asserts done during the k-th WAIT cycle.
    task automatic respond(input int k);
        repeat (k) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    int p0, h0;

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 4'hF;
        for (int i = 0; i < 4; i++)  rom2[i] = 4'h0;

        // ---- Program [0001, 0011, 1111], done two cycles after start ----
        rom[0] = 4'h1; rom[1] = 4'h3; rom[2] = 4'hF;
        do_reset();
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_opr", 32'(opr), 32'd0);
        check("rst_start", 32'(start), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_err_code", 32'(err_code), 32'd0);
        check("rst_count", 32'(issued_count), 32'd0);
        p0 = pulses; h0 = hi_cycles;
        run = 1'b1;
        tick();
        run = 1'b0;
        check("t1_fetch_start_low", 32'(start), 32'd0);
        check("t1_fetch_busy", 32'(busy), 32'd1);
        tick();
        check("t1_start_latency", 32'(start), 32'd1);
        check("t1_opr0", 32'(opr), 32'h1);
        respond(2);
        check("t1_pc_after_op0", 32'(pc), 32'd1);
        check("t1_count_after_op0", 32'(issued_count), 32'd1);
        tick();
        check("t1_start_op1", 32'(start), 32'd1);
        check("t1_opr1", 32'(opr), 32'h3);
        respond(2);
        tick();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_busy_halt", 32'(busy), 32'd0);
        check("t1_pc_halt", 32'(pc), 32'd2);
        check("t1_count_halt", 32'(issued_count), 32'd2);
        check("t1_pulses", 32'(pulses - p0), 32'd2);
        check("t1_high_cycles", 32'(hi_cycles - h0), 32'd2);
        check("t1_log0", 32'(opr_log[p0 % 16]), 32'h1);
        check("t1_log1", 32'(opr_log[(p0 + 1) % 16]), 32'h3);

        // ---- Program [0100, 0111]: invalid opcode at pc 1 ----
        rom[0] = 4'h4; rom[1] = 4'h7;
        do_reset();
        p0 = pulses;
        start_run();
        check("t2_opr0", 32'(opr), 32'h4);
        respond(1);
        tick();
        check("t2_error", 32'(error), 32'd1);
        check("t2_err_code", 32'(err_code), 32'b01);
        check("t2_pc", 32'(pc), 32'd1);
        check("t2_count", 32'(issued_count), 32'd1);
        check("t2_busy", 32'(busy), 32'd0);
        check("t2_opr_held", 32'(opr), 32'h4);
        start_run();
        tick();
        check("t2_run_ignored_err", 32'(error), 32'd1);
        check("t2_run_ignored_pc", 32'(pc), 32'd1);
        check("t2_pulses", 32'(pulses - p0), 32'd1);

        // ---- Program [1000], done never arrives: timeout ----
        rom[0] = 4'h8; rom[1] = 4'hF;
        do_reset();
        start_run();
        check("t3_start", 32'(start), 32'd1);
        repeat (63) tick();
        check("t3_no_err_wait63", 32'(error), 32'd0);
        check("t3_busy_wait63", 32'(busy), 32'd1);
        tick();
        check("t3_timeout_error", 32'(error), 32'd1);
        check("t3_timeout_code", 32'(err_code), 32'b10);
        check("t3_timeout_count", 32'(issued_count), 32'd0);

        // Variant: done on the 63rd WAIT cycle wins over the watchdog.
        do_reset();
        start_run();
        respond(63);
        check("t3v_count", 32'(issued_count), 32'd1);
        check("t3v_error", 32'(error), 32'd0);
        check("t3v_err_code", 32'(err_code), 32'b00);
        tick();
        check("t3v_halted", 32'(halted), 32'd1);

        // ---- Program [0010, 1111], stray done in IDLE, done held 5 cycles ----
        rom[0] = 4'h2; rom[1] = 4'hF;
        do_reset();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        check("t4_idle_done_count", 32'(issued_count), 32'd0);
        check("t4_idle_done_busy", 32'(busy), 32'd0);
        p0 = pulses;
        start_run();
        tick();
        done = 1'b1;
        repeat (5) tick();
        done = 1'b0;
        check("t4_held_done_count", 32'(issued_count), 32'd1);
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_pulses", 32'(pulses - p0), 32'd1);

        // ---- Reset during WAIT of 1001 ----
        rom[0] = 4'h9; rom[1] = 4'hF;
        do_reset();
        start_run();
        tick();
        tick();
        check("t5_in_wait_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_start", 32'(start), 32'd0);
        check("t5_rst_pc", 32'(pc), 32'd0);
        check("t5_rst_count", 32'(issued_count), 32'd0);
        check("t5_rst_halted", 32'(halted), 32'd0);
        done = 1'b1;
        tick();
        done = 1'b0;
        check("t5_late_done_count", 32'(issued_count), 32'd0);
        check("t5_late_done_busy", 32'(busy), 32'd0);
        start_run();
        check("t5_rerun_start", 32'(start), 32'd1);
        check("t5_rerun_opr", 32'(opr), 32'h9);
        check("t5_rerun_pc", 32'(pc), 32'd0);
        respond(1);
        tick();
        check("t5_rerun_halted", 32'(halted), 32'd1);
        check("t5_rerun_pc_end", 32'(pc), 32'd1);
        check("t5_rerun_count", 32'(issued_count), 32'd1);

        // ---- PC_W=2, four 0000 opcodes, no HALT entry ----
        do_reset();
        run2 = 1'b1;
        tick();
        run2 = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t6_start_op%0d", i), 32'(start2), 32'd1);
            check($sformatf("t6_pc_op%0d", i), 32'(pc2), 32'(i));
            tick();
            done2 = 1'b1;
            tick();
            done2 = 1'b0;
            if (i < 3) tick();
        end
        check("t6_halted", 32'(halted2), 32'd1);
        check("t6_pc", 32'(pc2), 32'd3);
        check("t6_count", 32'(issued_count2), 32'd4);
        check("t6_busy", 32'(busy2), 32'd0);
        repeat (3) tick();
        check("t6_pc_no_wrap", 32'(pc2), 32'd3);
        check("t6_error", 32'(error2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
